// File: rtl/tcam_host.sv
// Command-side controller for a ternary CAM: initialises every entry after reset,
// then serves write and lookup commands over valid/ready with tristate address ownership.
module tcam_host #(
  parameter int                     word_length    = 8,
  parameter int                     address_length = 2,
  parameter int                     lookup_latency = 1,
  parameter logic [word_length-1:0] init_word      = '1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [word_length-1:0]    cmd_word,
  input  logic [address_length-1:0] cmd_address,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [address_length-1:0] rsp_address,
  output logic                      init_done,
  output logic [word_length-1:0]    tcam_word,
  output logic                      tcam_R_Wb,
  inout  wire  [address_length-1:0] tcam_address
);

  localparam int LAT_W = (lookup_latency > 1) ? $clog2(lookup_latency) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(lookup_latency - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_LOOKUP,
    S_RESP
  } state_e;

  state_e                    state_q;
  logic [address_length-1:0] init_cnt_q;
  logic [LAT_W-1:0]          lat_cnt_q;
  logic [word_length-1:0]    word_q;
  logic [address_length-1:0] addr_q;
  logic                      r_wb_q;
  logic                      cmd_ready_q;
  logic                      rsp_valid_q;
  logic [address_length-1:0] rsp_address_q;
  logic                      init_done_q;

  // NOTE: the bus enable and R_Wb come from the same flop, so the controller
  // releases the address pins in the very cycle the TCAM starts driving them.
  assign tcam_address = r_wb_q ? {address_length{1'bz}} : addr_q;

  assign tcam_R_Wb   = r_wb_q;
  assign tcam_word   = word_q;
  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_address = rsp_address_q;
  assign init_done   = init_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_INIT;
      init_cnt_q    <= '0;
      lat_cnt_q     <= '0;
      word_q        <= init_word;
      addr_q        <= '0;
      r_wb_q        <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_address_q <= '0;
      init_done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          if (init_cnt_q == '1) begin
            state_q     <= S_IDLE;
            init_cnt_q  <= '0;
            r_wb_q      <= 1'b1;
            init_done_q <= 1'b1;
            cmd_ready_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + address_length'(1);
            addr_q     <= init_cnt_q + address_length'(1);
          end
        end

        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            word_q      <= cmd_word;
            addr_q      <= cmd_address;
            cmd_ready_q <= 1'b0;
            if (cmd_write) begin
              r_wb_q  <= 1'b0;
              state_q <= S_WRITE;
            end else begin
              lat_cnt_q <= '0;
              state_q   <= S_LOOKUP;
            end
          end
        end

        S_WRITE: begin
          r_wb_q      <= 1'b1;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        S_LOOKUP: begin
          // Unknown or high-Z results (no matching entry) are captured as-is.
          if (lat_cnt_q == LAT_LAST) begin
            rsp_address_q <= tcam_address;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_INIT;
          init_cnt_q  <= '0;
          addr_q      <= '0;
          r_wb_q      <= 1'b0;
          word_q      <= init_word;
          cmd_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
